outport_uart_tx: RTL and testbench

Serial back-end for the CPU output port. It consumes each 32-bit word the datapath writes to its output port and buffers it in a small word FIFO. Each word is transmitted as four 8N1 UART bytes on a single txd pin, least-significant byte first. It sits directly downstream of the datapath's OutportData, in parallel with the seven-segment display path.

---
 rtl/outport_uart_tx_if.sv | 26 ++
 rtl/outport_uart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_outport_uart_tx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/outport_uart_tx_if.sv
// Write channel and status/line signals of the output-port UART transmitter.
// The datapath side uses the master modport and the transmitter uses the slave modport.
interface outport_uart_tx_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   wr_data;
   logic          wr;
   logic          full;
   logic          empty;
   logic [CW-1:0] fifo_count;
   logic          busy;
   logic          overflow;
   logic          txd;

   modport master (
      output wr_data, wr,
      input  full, empty, fifo_count, busy, overflow, txd
   );

   modport slave (
      input  wr_data, wr,
      output full, empty, fifo_count, busy, overflow, txd
   );
endinterface

// File: rtl/outport_uart_tx.sv
// Buffers output-port words in a small FIFO and sends each one as four UART bytes, LSB first.
// Define OUTPORT_UART_TX_PARITY_EN to get 8E1 framing; otherwise the framing is 8N1.
module outport_uart_tx #(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   outport_uart_tx_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [15:0]   BAUD_LAST  = 16'(CLK_DIV - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

`ifdef OUTPORT_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

   function automatic logic evenParity(input logic [7:0] b);
      return ^b;
   endfunction

   state_t        state_r, stateNext_s;
   logic          txd_r, txdNext_s;
   logic          busy_r;
   logic [15:0]   baudCnt_r, baudNext_s;
   logic [2:0]    bitIdx_r, bitNext_s;
   logic [1:0]    byteIdx_r, byteNext_s;
   logic [31:0]   shift_r, shiftNext_s;
   logic [31:0]   mem_r [FIFO_DEPTH];
   logic [PW-1:0] wrPtr_r, rdPtr_r;
   logic [CW-1:0] count_r, countNext_s;
   logic          full_r, empty_r, overflow_r;
   logic          push_s, pop_s, baudDone_s;
   logic [7:0]    curByte_s;

   // Eligibility uses the registered full flag, so a same-edge pop never rescues a push.
   assign push_s     = bus.wr & ~full_r;
   assign baudDone_s = (baudCnt_r == BAUD_LAST);
   assign curByte_s  = shift_r[7:0];

   // Next-state, line level and pop decision for the framing FSM.
   always_comb begin
      stateNext_s = state_r;
      txdNext_s   = txd_r;
      baudNext_s  = baudCnt_r;
      bitNext_s   = bitIdx_r;
      byteNext_s  = byteIdx_r;
      shiftNext_s = shift_r;
      pop_s       = 1'b0;
      case (state_r)
         IDLE: begin
            baudNext_s = 16'd0;
            if (!empty_r) begin
               pop_s       = 1'b1;
               shiftNext_s = mem_r[rdPtr_r];
               byteNext_s  = 2'd0;
               stateNext_s = START;
               txdNext_s   = 1'b0;
            end else begin
               txdNext_s = 1'b1;
            end
         end
         START: begin
            if (baudDone_s) begin
               baudNext_s  = 16'd0;
               bitNext_s   = 3'd0;
               stateNext_s = DATA;
               txdNext_s   = curByte_s[0];
            end else begin
               baudNext_s = baudCnt_r + 16'd1;
            end
         end
         DATA: begin
            if (baudDone_s) begin
               baudNext_s = 16'd0;
               if (bitIdx_r == 3'd7) begin
`ifdef OUTPORT_UART_TX_PARITY_EN
                  stateNext_s = PARITY;
                  txdNext_s   = evenParity(curByte_s);
`else
                  stateNext_s = STOP;
                  txdNext_s   = 1'b1;
`endif
               end else begin
                  bitNext_s = bitIdx_r + 3'd1;
                  txdNext_s = curByte_s[bitIdx_r + 3'd1];
               end
            end else begin
               baudNext_s = baudCnt_r + 16'd1;
            end
         end
`ifdef OUTPORT_UART_TX_PARITY_EN
         PARITY: begin
            if (baudDone_s) begin
               baudNext_s  = 16'd0;
               stateNext_s = STOP;
               txdNext_s   = 1'b1;
            end else begin
               baudNext_s = baudCnt_r + 16'd1;
            end
         end
`endif
         STOP: begin
            if (baudDone_s) begin
               baudNext_s = 16'd0;
               if (byteIdx_r != 2'd3) begin
                  byteNext_s  = byteIdx_r + 2'd1;
                  shiftNext_s = {8'h00, shift_r[31:8]};
                  stateNext_s = START;
                  txdNext_s   = 1'b0;
               end else if (!empty_r) begin
                  // Chain straight into the next word with no idle gap.
                  pop_s       = 1'b1;
                  shiftNext_s = mem_r[rdPtr_r];
                  byteNext_s  = 2'd0;
                  stateNext_s = START;
                  txdNext_s   = 1'b0;
               end else begin
                  stateNext_s = IDLE;
                  txdNext_s   = 1'b1;
               end
            end else begin
               baudNext_s = baudCnt_r + 16'd1;
            end
         end
         default: begin
            stateNext_s = IDLE;
            txdNext_s   = 1'b1;
            baudNext_s  = 16'd0;
         end
      endcase
   end

   // Occupancy after this edge's push and pop.
   always_comb begin
      countNext_s = count_r;
      if (push_s && !pop_s) begin
         countNext_s = count_r + CW'(1);
      end else if (pop_s && !push_s) begin
         countNext_s = count_r - CW'(1);
      end else begin
         countNext_s = count_r;
      end
   end

   // FSM, shifter and line output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         txd_r     <= 1'b1;
         busy_r    <= 1'b0;
         baudCnt_r <= 16'd0;
         bitIdx_r  <= 3'd0;
         byteIdx_r <= 2'd0;
         shift_r   <= 32'd0;
      end else begin
         state_r   <= stateNext_s;
         txd_r     <= txdNext_s;
         busy_r    <= (stateNext_s != IDLE);
         baudCnt_r <= baudNext_s;
         bitIdx_r  <= bitNext_s;
         byteIdx_r <= byteNext_s;
         shift_r   <= shiftNext_s;
      end
   end

   // FIFO pointers and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_r    <= {PW{1'b0}};
         rdPtr_r    <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) wrPtr_r <= wrPtr_r + PW'(1);
         if (pop_s)  rdPtr_r <= rdPtr_r + PW'(1);
         count_r    <= countNext_s;
         full_r     <= (countNext_s == COUNT_FULL);
         empty_r    <= (countNext_s == {CW{1'b0}});
         overflow_r <= overflow_r | (bus.wr & full_r);
      end
   end

   // Word storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (!reset && push_s) mem_r[wrPtr_r] <= bus.wr_data;
   end

   assign bus.txd        = txd_r;
   assign bus.busy       = busy_r;
   assign bus.full       = full_r;
   assign bus.empty      = empty_r;
   assign bus.fifo_count = count_r;
   assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx: a line monitor decodes txd and checks bytes against a scoreboard.
module tb_outport_uart_tx;
   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;
`ifdef OUTPORT_UART_TX_PARITY_EN
   localparam int BITS = 11;
`else
   localparam int BITS = 10;
`endif
   localparam int BYTE_CYC = BITS * CLK_DIV;
   localparam int FRAME    = 4 * BYTE_CYC;

   logic clk = 1'b0;
   logic reset;

   outport_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

   outport_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;
   int   cycle  = 0;
   logic [7:0] expQ [$];
   int   startQ [$];
   logic dropNext = 1'b0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushWord(input logic [31:0] w);
      for (int i = 0; i < 4; i++) expQ.push_back(w[8*i +: 8]);
   endtask

   task automatic wrWord(input logic [31:0] w);
      bus.wr_data = w;
      bus.wr      = 1'b1;
      tick();
      bus.wr      = 1'b0;
      bus.wr_data = 32'hDEAD_0000;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((bus.busy !== 1'b0 || expQ.size() != 0) && n < 4000) begin
         tick();
         n++;
      end
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_rxq"}, expQ.size(), 32'd0);
      repeat (3) tick();
   endtask

   // Line monitor: detects start bits on the falling clock edge and samples mid-bit.
   initial begin
      logic [7:0] rx;
      logic       par, stopBit;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && bus.txd === 1'b0) begin
            startQ.push_back(cycle);
            repeat (2) @(negedge clk);
            check("start_bit", {31'd0, bus.txd}, 32'd0);
            for (int b = 0; b < 8; b++) begin
               repeat (CLK_DIV) @(negedge clk);
               rx[b] = bus.txd;
            end
            par = 1'b0;
`ifdef OUTPORT_UART_TX_PARITY_EN
            repeat (CLK_DIV) @(negedge clk);
            par = bus.txd;
`endif
            repeat (CLK_DIV) @(negedge clk);
            stopBit = bus.txd;
            if (dropNext) begin
               dropNext = 1'b0;
            end else begin
               check("stop_bit", {31'd0, stopBit}, 32'd1);
`ifdef OUTPORT_UART_TX_PARITY_EN
               check("parity_bit", {31'd0, par}, {31'd0, ^rx});
`endif
               check("rx_expected", {31'd0, expQ.size() != 0}, 32'd1);
               if (expQ.size() != 0) check("rx_byte", {24'd0, rx}, {24'd0, expQ.pop_front()});
            end
         end
      end
   end

   initial begin
      int n;
      int lowCnt;
      reset       = 1'b1;
      bus.wr      = 1'b0;
      bus.wr_data = 32'd0;

      // Reset and idle line
      repeat (3) begin
         tick();
         check("rst_txd", {31'd0, bus.txd}, 32'd1);
         check("rst_empty", {31'd0, bus.empty}, 32'd1);
      end
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_full", {31'd0, bus.full}, 32'd0);
      check("rst_count", {29'd0, bus.fifo_count}, 32'd0);
      check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
      reset = 1'b0;
      repeat (20) begin
         tick();
         check("idle_line", {27'd0, bus.txd, bus.busy, bus.empty, bus.full, bus.overflow}, 32'b10100);
         check("idle_count", {29'd0, bus.fifo_count}, 32'd0);
      end

      // Single word: latency, busy length, byte order
      pushWord(32'h1234_5678);
      wrWord(32'h1234_5678);
      check("w1_empty", {31'd0, bus.empty}, 32'd0);
      check("w1_txd_pre", {31'd0, bus.txd}, 32'd1);
      check("w1_busy_pre", {31'd0, bus.busy}, 32'd0);
      tick();
      check("w1_txd_fall", {31'd0, bus.txd}, 32'd0);
      check("w1_busy", {31'd0, bus.busy}, 32'd1);
      check("w1_count", {29'd0, bus.fifo_count}, 32'd0);
      n = 0;
      while (bus.busy === 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      check("w1_busy_len", n, FRAME);
      drain("w1");

      // Fill and overflow: the pop after the first push frees one slot
      startQ.delete();
      for (int i = 0; i < 5; i++) begin
         pushWord(32'hA0 + i);
         wrWord(32'hA0 + i);
      end
      check("fill_count", {29'd0, bus.fifo_count}, 32'd4);
      check("fill_full", {31'd0, bus.full}, 32'd1);
      check("fill_ovf_pre", {31'd0, bus.overflow}, 32'd0);
      wrWord(32'hA5);
      check("ovf_set", {31'd0, bus.overflow}, 32'd1);
      check("ovf_count", {29'd0, bus.fifo_count}, 32'd4);
      drain("fill");
      check("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
      check("fill_starts", startQ.size(), 32'd20);
      for (int i = 1; i < startQ.size(); i++) check("fill_gap", startQ[i] - startQ[i-1], BYTE_CYC);

      // Back-to-back words with no gap between frames
      startQ.delete();
      pushWord(32'hCAFE_F00D);
      wrWord(32'hCAFE_F00D);
      repeat (50) tick();
      pushWord(32'h0BAD_BEEF);
      wrWord(32'h0BAD_BEEF);
      drain("b2b");
      check("b2b_starts", startQ.size(), 32'd8);
      for (int i = 1; i < startQ.size(); i++) check("b2b_gap", startQ[i] - startQ[i-1], BYTE_CYC);

      // Push coincident with the end-of-word pop while two words wait
      pushWord(32'h1111_0000);
      wrWord(32'h1111_0000);
      tick();
      pushWord(32'h2222_0001);
      wrWord(32'h2222_0001);
      pushWord(32'h3333_0002);
      wrWord(32'h3333_0002);
      repeat (FRAME - 3) tick();
      check("pp_count_pre", {29'd0, bus.fifo_count}, 32'd2);
      check("pp_txd_stop", {31'd0, bus.txd}, 32'd1);
      pushWord(32'h4444_0003);
      wrWord(32'h4444_0003);
      check("pp_count_post", {29'd0, bus.fifo_count}, 32'd2);
      check("pp_txd_start", {31'd0, bus.txd}, 32'd0);
      check("pp_busy", {31'd0, bus.busy}, 32'd1);
      drain("pp");

      // Reset during DATA of byte 2 with two words queued
      expQ.push_back(8'h01);
      expQ.push_back(8'h02);
      wrWord(32'h0403_0201);
      tick();
      wrWord(32'h5555_5555);
      wrWord(32'h6666_6666);
      repeat (2 * BYTE_CYC + CLK_DIV + 4) tick();
      check("mid_count", {29'd0, bus.fifo_count}, 32'd2);
      check("mid_ovf", {31'd0, bus.overflow}, 32'd1);
      check("mid_rxq", expQ.size(), 32'd0);
      dropNext = 1'b1;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
      check("mid_rst_txd", {31'd0, bus.txd}, 32'd1);
      check("mid_rst_count", {29'd0, bus.fifo_count}, 32'd0);
      check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("mid_rst_ovf", {31'd0, bus.overflow}, 32'd0);
      check("mid_rst_empty", {31'd0, bus.empty}, 32'd1);
      lowCnt = 0;
      repeat (2 * FRAME) begin
         tick();
         if (bus.txd !== 1'b1) lowCnt++;
      end
      check("mid_no_start", lowCnt, 32'd0);
      check("mid_drop_done", {31'd0, dropNext}, 32'd0);
      check("final_rxq", expQ.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
